// File: rtl/timing_sync_ctrl_pkg.sv
// rtl/timing_sync_ctrl_pkg.sv - shared states and derived widths for the timing-sync controller
package timing_sync_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FILL   = 3'd2,
    SEARCH = 3'd3,
    PEAK   = 3'd4
  } state_t;

  localparam int THR_W    = 8;
  localparam int THR_FRAC = 8;

  // |P|^2 needs one bit beyond a single square to hold Pr^2+Pi^2.
  function automatic int metric_w(input int wl);
    return 2 * wl + 1;
  endfunction

  function automatic int lhs_w(input int wl);
    return 2 * wl + 1 + THR_FRAC;
  endfunction

  function automatic int rhs_w(input int wl);
    return 2 * wl + THR_W;
  endfunction

endpackage

// File: rtl/timing_sync_ctrl_if.sv
// rtl/timing_sync_ctrl_if.sv - sample/command/result bundle between datapath, controller and consumers
interface timing_sync_ctrl_if #(
  parameter int WL    = 24,
  parameter int IDX_W = 16
);

  logic                 start;
  logic [7:0]           thr_q8;
  logic                 sum_valid;
  logic signed [WL-1:0] sum_corr_real;
  logic signed [WL-1:0] sum_corr_imag;
  logic signed [WL-1:0] sum_energy;
  logic                 sum_clear;
  logic                 busy;
  logic                 det_valid;
  logic [IDX_W-1:0]     det_index;
  logic [2*WL:0]        det_metric;
  logic                 timeout;

  modport master (
    output start, thr_q8, sum_valid, sum_corr_real, sum_corr_imag, sum_energy,
    input  sum_clear, busy, det_valid, det_index, det_metric, timeout
  );

  modport slave (
    input  start, thr_q8, sum_valid, sum_corr_real, sum_corr_imag, sum_energy,
    output sum_clear, busy, det_valid, det_index, det_metric, timeout
  );

endinterface

// File: rtl/timing_sync_ctrl_metric_stage.sv
// rtl/timing_sync_ctrl_metric_stage.sv - registered |P|^2 vs thr*R^2 threshold test
module sync_metric_stage
  import timing_sync_pkg::*;
#(
  parameter  int WL    = 24,
  parameter  int IDX_W = 16,
  localparam int MW    = metric_w(WL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [THR_W-1:0]     i_thr_q8,
  input  logic signed [WL-1:0] i_pr,
  input  logic signed [WL-1:0] i_pi,
  input  logic signed [WL-1:0] i_r,
  input  logic [IDX_W-1:0]     i_idx,
  output logic                 o_valid,
  output logic                 o_above,
  output logic [MW-1:0]        o_pmag,
  output logic [IDX_W-1:0]     o_idx
);

  localparam int LW = lhs_w(WL);
  localparam int RW = rhs_w(WL);
  localparam int SQ = 2 * WL;

  logic signed [SQ-1:0] w_pr_x;
  logic signed [SQ-1:0] w_pi_x;
  logic signed [SQ-1:0] w_r_x;
  logic [SQ-1:0]        w_pr2;
  logic [SQ-1:0]        w_pi2;
  logic [SQ-1:0]        w_r2;
  logic [MW-1:0]        w_pmag;
  logic [LW-1:0]        w_lhs;
  logic [RW-1:0]        w_rhs;
  logic                 w_r_pos;
  logic                 w_above;

  assign w_pr_x = SQ'(i_pr);
  assign w_pi_x = SQ'(i_pi);
  assign w_r_x  = SQ'(i_r);

  // Squares of signed values are non-negative and fit in 2*WL bits.
  assign w_pr2  = w_pr_x * w_pr_x;
  assign w_pi2  = w_pi_x * w_pi_x;
  assign w_r2   = w_r_x * w_r_x;

  assign w_pmag = {1'b0, w_pr2} + {1'b0, w_pi2};
  assign w_lhs  = {w_pmag, {THR_FRAC{1'b0}}};
  assign w_rhs  = RW'(w_r2) * RW'(i_thr_q8);

  assign w_r_pos = !i_r[WL-1] && (i_r != '0);
  assign w_above = w_r_pos && (w_lhs > LW'(w_rhs));

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_above <= 1'b0;
      o_pmag  <= '0;
      o_idx   <= '0;
    end else begin
      o_valid <= i_valid;
      o_above <= i_valid && w_above;
      o_pmag  <= w_pmag;
      o_idx   <= i_idx;
    end
  end

endmodule

// File: rtl/timing_sync_ctrl.sv
// rtl/timing_sync_ctrl.sv - acquisition sequencer: clear, fill, threshold search, peak window, report
module timing_sync_ctrl
  import timing_sync_pkg::*;
#(
  parameter int WL         = 24,
  parameter int L          = 16,
  parameter int PEAK_WIN   = 32,
  parameter int MAX_SEARCH = 4096,
  parameter int IDX_W      = 16
) (
  input logic               clk,
  input logic               rst,
  timing_sync_ctrl_if.slave bus
);

  localparam int MW = metric_w(WL);
  localparam int SW = $clog2(MAX_SEARCH + 1);
  localparam int PW = $clog2(PEAK_WIN + 1);
  localparam logic [IDX_W-1:0] IDX_MAX   = '1;
  localparam logic [IDX_W-1:0] FILL_LAST = IDX_W'(L - 2);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic [SW-1:0]    r_search_cnt;
  logic [PW-1:0]    r_win_cnt;
  logic [MW-1:0]    r_peak;
  logic [IDX_W-1:0] r_peak_idx;
  logic             r_det_valid;
  logic [IDX_W-1:0] r_det_index;
  logic [MW-1:0]    r_det_metric;
  logic             r_timeout;

  logic             w_eval_in;
  logic             w_st_valid;
  logic             w_st_above;
  logic [MW-1:0]    w_st_pmag;
  logic [IDX_W-1:0] w_st_idx;
  logic             w_fill_done;
  logic             w_search_to;
  logic             w_peak_upd;
  logic             w_peak_done;
  logic [MW-1:0]    w_cand_metric;
  logic [IDX_W-1:0] w_cand_idx;

  // Only samples arriving once the window is full enter the evaluation pipe.
  assign w_eval_in = bus.sum_valid && ((r_state == SEARCH) || (r_state == PEAK));

  sync_metric_stage #(
    .WL    (WL),
    .IDX_W (IDX_W)
  ) u_metric (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (w_eval_in),
    .i_thr_q8 (bus.thr_q8),
    .i_pr     (bus.sum_corr_real),
    .i_pi     (bus.sum_corr_imag),
    .i_r      (bus.sum_energy),
    .i_idx    (r_idx),
    .o_valid  (w_st_valid),
    .o_above  (w_st_above),
    .o_pmag   (w_st_pmag),
    .o_idx    (w_st_idx)
  );

  assign w_fill_done = (r_state == FILL) && bus.sum_valid && (r_idx == FILL_LAST);
  assign w_search_to = (r_state == SEARCH) && w_st_valid && !w_st_above
                       && (r_search_cnt == SW'(MAX_SEARCH - 1));
  assign w_peak_upd  = (r_state == PEAK) && w_st_valid && w_st_above && (w_st_pmag > r_peak);
  assign w_peak_done = w_st_valid
                       && (((r_state == PEAK) && (r_win_cnt == PW'(PEAK_WIN - 1)))
                           || ((r_state == SEARCH) && w_st_above && (PEAK_WIN == 1)));

  // Strict compare above keeps the earliest of equal maxima.
  assign w_cand_metric = ((r_state == SEARCH) || w_peak_upd) ? w_st_pmag : r_peak;
  assign w_cand_idx    = ((r_state == SEARCH) || w_peak_upd) ? w_st_idx  : r_peak_idx;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = CLEAR;
      CLEAR:   w_next = FILL;
      FILL:    if (w_fill_done) w_next = SEARCH;
      SEARCH: begin
        if (w_peak_done || w_search_to)  w_next = IDLE;
        else if (w_st_valid && w_st_above) w_next = PEAK;
      end
      PEAK:    if (w_peak_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.sum_clear = (r_state == CLEAR);
    bus.busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_search_cnt <= '0;
      r_win_cnt    <= '0;
      r_peak       <= '0;
      r_peak_idx   <= '0;
      r_det_valid  <= 1'b0;
      r_det_index  <= '0;
      r_det_metric <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_det_valid <= 1'b0;
      r_timeout   <= 1'b0;

      if (r_state == CLEAR)                       r_idx <= '0;
      else if (bus.sum_valid && r_idx != IDX_MAX) r_idx <= r_idx + 1'b1;

      if (r_state == CLEAR) begin
        r_search_cnt <= '0;
        r_win_cnt    <= '0;
      end

      if (w_st_valid && r_state == SEARCH) begin
        if (w_st_above) begin
          r_peak     <= w_st_pmag;
          r_peak_idx <= w_st_idx;
          r_win_cnt  <= PW'(1);
        end else begin
          r_search_cnt <= r_search_cnt + 1'b1;
        end
      end else if (w_st_valid && r_state == PEAK) begin
        r_win_cnt <= r_win_cnt + 1'b1;
        if (w_peak_upd) begin
          r_peak     <= w_st_pmag;
          r_peak_idx <= w_st_idx;
        end
      end

      if (w_peak_done) begin
        r_det_valid  <= 1'b1;
        r_det_index  <= w_cand_idx;
        r_det_metric <= w_cand_metric;
      end
      if (w_search_to) r_timeout <= 1'b1;
    end
  end

  assign bus.det_valid  = r_det_valid;
  assign bus.det_index  = r_det_index;
  assign bus.det_metric = r_det_metric;
  assign bus.timeout    = r_timeout;

endmodule

// File: tb/tb_timing_sync_ctrl.sv
// tb/tb_timing_sync_ctrl.sv - randomized and directed acquisitions against a sample-array reference model
module tb_timing_sync_ctrl;

  localparam int WL    = 24;
  localparam int L     = 16;
  localparam int PW    = 32;
  localparam int MAXS  = 64;
  localparam int IDX_W = 16;
  localparam int N     = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  timing_sync_ctrl_if #(.WL(WL), .IDX_W(IDX_W)) bus ();

  timing_sync_ctrl #(
    .WL         (WL),
    .L          (L),
    .PEAK_WIN   (PW),
    .MAX_SEARCH (MAXS),
    .IDX_W      (IDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int pr_a [N];
  int pi_a [N];
  int r_a  [N];
  int scyc [N];
  int thr;

  int     exp_kind, exp_term, exp_first, exp_idx;
  longint exp_met;
  logic [63:0] last_idx = 0;
  logic [63:0] last_met = 0;

  int          ev_n, ev_cyc;
  logic        ev_det, ev_to, ev_busy;
  logic [63:0] ev_idx, ev_met;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.det_valid || bus.timeout) begin
      ev_n++;
      if (ev_n == 1) begin
        ev_cyc  = cyc;
        ev_det  = bus.det_valid;
        ev_to   = bus.timeout;
        ev_idx  = 64'(bus.det_index);
        ev_met  = 64'(bus.det_metric);
        ev_busy = bus.busy;
      end
    end
  endtask

  function automatic longint pmag(input int i);
    return longint'(pr_a[i]) * longint'(pr_a[i]) + longint'(pi_a[i]) * longint'(pi_a[i]);
  endfunction

  function automatic bit above(input int i);
    return (r_a[i] > 0) && (pmag(i) * 256 > longint'(thr) * longint'(r_a[i]) * longint'(r_a[i]));
  endfunction

  // Outcome straight from the rules: first crossing among the first MAXS full-window
  // samples opens a PW-sample window whose earliest strict maximum is reported.
  task automatic model();
    exp_kind  = 2;
    exp_term  = L - 1 + MAXS - 1;
    exp_first = -1;
    exp_idx   = 0;
    exp_met   = 0;
    for (int e = 0; e < MAXS; e++) begin
      if (above(L - 1 + e)) begin
        exp_kind  = 1;
        exp_first = L - 1 + e;
        exp_term  = exp_first + PW - 1;
        exp_idx   = exp_first;
        exp_met   = pmag(exp_first);
        for (int j = exp_first + 1; j <= exp_term; j++)
          if (above(j) && pmag(j) > exp_met) begin
            exp_idx = j;
            exp_met = pmag(j);
          end
        break;
      end
    end
  endtask

  task automatic run_acq(input string nm, input int rst_off);
    int rst_at;
    model();
    rst_at = (rst_off >= 0 && exp_kind == 1) ? exp_first + rst_off : -1;
    ev_n = 0;
    ev_cyc = -100;
    bus.thr_q8 = 8'(thr);
    tick(); bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    check({nm, ".clear_on"}, 64'(bus.sum_clear), 1);
    check({nm, ".busy_on"}, 64'(bus.busy), 1);
    bus.sum_valid = 1'b1;
    bus.sum_corr_real = WL'(5000);
    bus.sum_corr_imag = '0;
    bus.sum_energy = WL'(1000);
    tick(); bus.sum_valid = 1'b0;
    check({nm, ".clear_off"}, 64'(bus.sum_clear), 0);
    for (int i = 0; i <= exp_term; i++) begin
      repeat ($urandom_range(0, 2)) begin
        tick(); bus.sum_valid = 1'b0;
      end
      tick();
      bus.sum_valid = 1'b1;
      bus.sum_corr_real = WL'(pr_a[i]);
      bus.sum_corr_imag = WL'(pi_a[i]);
      bus.sum_energy = WL'(r_a[i]);
      bus.start = (exp_kind == 1 && i == exp_first + 3);
      scyc[i] = cyc;
      if (i == rst_at) begin
        tick(); bus.sum_valid = 1'b0; bus.start = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0;
        check({nm, ".rst_busy"}, 64'(bus.busy), 0);
        check({nm, ".rst_idx"}, 64'(bus.det_index), 0);
        check({nm, ".rst_met"}, 64'(bus.det_metric), 0);
        repeat (40) tick();
        check({nm, ".rst_no_event"}, 64'(ev_n), 0);
        last_idx = 0;
        last_met = 0;
        return;
      end
    end
    tick(); bus.sum_valid = 1'b0; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    repeat (4) tick();
    check({nm, ".events"}, 64'(ev_n), 1);
    check({nm, ".kind"}, ev_det ? 64'd1 : (ev_to ? 64'd2 : 64'd0), 64'(exp_kind));
    check({nm, ".latency"}, 64'(ev_cyc - scyc[exp_term]), 2);
    if (exp_kind == 1) begin
      last_idx = 64'(exp_idx);
      last_met = 64'(exp_met);
    end
    check({nm, ".det_index"}, ev_idx, last_idx);
    check({nm, ".det_metric"}, ev_met, last_met);
    check({nm, ".busy_at_event"}, 64'(ev_busy), 0);
    check({nm, ".busy_after"}, 64'(bus.busy), 0);
  endtask

  task automatic fill_flat(input int pr, input int r);
    for (int i = 0; i < N; i++) begin
      pr_a[i] = pr;
      pi_a[i] = 0;
      r_a[i]  = r;
    end
  endtask

  task automatic gen_random();
    bit spike;
    int f0;
    thr   = $urandom_range(16, 255);
    spike = ($urandom_range(0, 3) != 0);
    f0    = $urandom_range(10, 75);
    for (int i = 0; i < N; i++) begin
      pr_a[i] = int'($urandom_range(0, 400)) - 200;
      pi_a[i] = int'($urandom_range(0, 400)) - 200;
      r_a[i]  = $urandom_range(800, 1200);
      if ($urandom_range(0, 9) == 0) r_a[i] = -int'($urandom_range(0, 1000));
      if (spike && i >= f0 && i < f0 + 40) begin
        pr_a[i] = 600 + 200 * int'($urandom_range(0, 4));
        pi_a[i] = ($urandom_range(0, 1) == 1) ? -300 : 0;
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.thr_q8 = '0;
    bus.sum_valid = 1'b0;
    bus.sum_corr_real = '0;
    bus.sum_corr_imag = '0;
    bus.sum_energy = '0;
    ev_n = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset.sum_clear", 64'(bus.sum_clear), 0);
    check("reset.busy", 64'(bus.busy), 0);
    check("reset.det_valid", 64'(bus.det_valid), 0);
    check("reset.timeout", 64'(bus.timeout), 0);
    check("reset.det_index", 64'(bus.det_index), 0);
    check("reset.det_metric", 64'(bus.det_metric), 0);

    tick(); bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    check("nosamp.clear_on", 64'(bus.sum_clear), 1);
    tick();
    check("nosamp.clear_off", 64'(bus.sum_clear), 0);
    repeat (20) tick();
    check("nosamp.busy_hold", 64'(bus.busy), 1);
    check("nosamp.clear_once", 64'(bus.sum_clear), 0);
    rst = 1'b1;
    tick(); rst = 1'b0;
    check("nosamp.rst_busy", 64'(bus.busy), 0);

    thr = 128;
    fill_flat(600, 1000);
    for (int i = 40; i <= 71; i++) pr_a[i] = 900 - 10 * ((i > 50) ? i - 50 : 50 - i);
    run_acq("plateau", -1);

    fill_flat(600, 1000);
    for (int i = 40; i <= 71; i++) pr_a[i] = 800;
    pr_a[45] = 900;
    pr_a[55] = 900;
    run_acq("tie", -1);

    fill_flat(0, 1000);
    run_acq("timeout", -1);

    fill_flat(500, 0);
    run_acq("zero_energy", -1);

    fill_flat(600, 1000);
    for (int i = 40; i <= 71; i++) pr_a[i] = 900 - 10 * ((i > 50) ? i - 50 : 50 - i);
    run_acq("rst_mid_peak", 5);

    for (int k = 0; k < 8; k++) begin
      gen_random();
      run_acq($sformatf("rand%0d", k), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
